// File: rtl/rf_arb_pkg.sv
// Shared constants and state encoding for the register-file access arbiter.
package rf_arb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational winner pick. Define RF_ARB_FIXED_PRIO_EN for fixed
// priority (req0 always wins); default build is round-robin on last_grant.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner
);
`ifdef RF_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = req0 ? REQ0 : (req1 ? REQ1 : REQ0);
  end
`else
  always_comb begin
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = REQ1;
    end else begin
      winner = REQ0;
    end
  end
`endif
endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one write port and one read port of an 8x32 register file between
// two req/ack masters. Arbitration policy is set inside rr_arb2.
module rf_access_arbiter #(
  parameter int DATA_W = rf_arb_pkg::DATA_W,
  parameter int ADDR_W = rf_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData
);
  import rf_arb_pkg::*;

  state_t              state_reg;
  logic                win_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                last_grant_reg;
  logic                pick;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_reg),
    .winner     (pick)
  );

  // Outputs are registered, so the port activity decided in a state becomes
  // visible in the following cycle: rf ports in the cycle after ACCESS,
  // ack/rdata in the cycle after RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rf_we          <= 1'b0;
      rf_wAddr       <= '0;
      rf_wData       <= '0;
      rf_rAddr       <= '0;
      rdata          <= '0;
      busy           <= 1'b0;
      last_grant_reg <= REQ1;
      win_reg        <= REQ0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      rf_we <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            win_reg   <= pick;
            we_reg    <= (pick == REQ1) ? we1 : we0;
            addr_reg  <= (pick == REQ1) ? addr1 : addr0;
            wdata_reg <= (pick == REQ1) ? wdata1 : wdata0;
            state_reg <= ACCESS;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            rf_we    <= 1'b1;
            rf_wAddr <= addr_reg;
            rf_wData <= wdata_reg;
          end else begin
            rf_rAddr <= addr_reg;
          end
          state_reg <= RESP;
        end
        RESP: begin
          if (!we_reg) begin
            rdata <= rf_rData;
          end
          ack0           <= (win_reg == REQ0);
          ack1           <= (win_reg == REQ1);
          last_grant_reg <= win_reg;
          state_reg      <= IDLE;
          busy           <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: directed scenarios plus random traffic against a
// transaction-level model; honours RF_ARB_FIXED_PRIO_EN like the design.
module tb_rf_access_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [2:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, rf_we;
  logic [31:0] rdata, rf_wData, rf_rData;
  logic [2:0]  rf_wAddr, rf_rAddr;

  int n_vec = 0;
  int n_err = 0;

  rf_access_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .rf_wAddr(rf_wAddr), .rf_wData(rf_wData), .rf_we(rf_we),
    .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read.
  logic [31:0] rf_mem [8] = '{default: 32'h0};
  assign rf_rData = rf_mem[rf_rAddr];
  always @(posedge clk) if (rf_we) rf_mem[rf_wAddr] <= rf_wData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access in flight, identified by its age in
  // clock edges since it was granted.
  logic [31:0] m_mem [8] = '{default: 32'h0};
  logic        m_valid = 1'b0;
  logic        m_ack0 = 1'b0, m_ack1 = 1'b0, m_we = 1'b0, m_busy = 1'b0;
  logic [2:0]  m_wa = '0, m_ra = '0;
  logic [31:0] m_wd = '0, m_rdata = '0;
  logic        m_last = 1'b1;
  logic        t_active = 1'b0, t_win = 1'b0, t_we = 1'b0;
  logic [2:0]  t_addr = '0;
  logic [31:0] t_wdata = '0;
  int          t_age = 0;

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      if (t_active && t_age == 1 && t_we) m_mem[t_addr] = t_wdata;
      t_active = 1'b0;
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_we = 1'b0; m_busy = 1'b0;
      m_wa = '0; m_wd = '0; m_ra = '0; m_rdata = '0; m_last = 1'b1;
    end else begin
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_we = 1'b0;
      if (t_active) begin
        t_age++;
        if (t_age == 1) begin
          if (t_we) begin
            m_we = 1'b1; m_wa = t_addr; m_wd = t_wdata;
          end else begin
            m_ra = t_addr;
          end
        end else begin
          if (t_we) m_mem[t_addr] = t_wdata;
          else m_rdata = m_mem[t_addr];
          if (t_win) m_ack1 = 1'b1; else m_ack0 = 1'b1;
          m_last = t_win;
          m_busy = 1'b0;
          t_active = 1'b0;
        end
      end else if (req0 || req1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        t_win = req0 ? 1'b0 : 1'b1;
`else
        t_win = (req0 && req1) ? !m_last : req1;
`endif
        t_we    = t_win ? we1 : we0;
        t_addr  = t_win ? addr1 : addr0;
        t_wdata = t_win ? wdata1 : wdata0;
        t_active = 1'b1;
        t_age = 0;
        m_busy = 1'b1;
      end
    end
    m_valid = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("ack0", {31'b0, ack0}, {31'b0, m_ack0});
      check("ack1", {31'b0, ack1}, {31'b0, m_ack1});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("rf_we", {31'b0, rf_we}, {31'b0, m_we});
      check("rf_wAddr", {29'b0, rf_wAddr}, {29'b0, m_wa});
      check("rf_wData", rf_wData, m_wd);
      check("rf_rAddr", {29'b0, rf_rAddr}, {29'b0, m_ra});
      check("rdata", rdata, m_rdata);
    end
  end

  // Called #1 after an edge with the arbiter idle; returns when ack is seen.
  task automatic run_txn(input int who, input logic we, input logic [2:0] a,
                         input logic [31:0] d, output int lat, output int we_cycles,
                         output logic [2:0] we_addr, output logic [31:0] rd);
    logic seen;
    seen = 1'b0; lat = 0; we_cycles = 0; we_addr = '0;
    if (who == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else          begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    for (int n = 0; n < 12 && !seen; n++) begin
      @(posedge clk); #1;
      lat++;
      if (rf_we) begin we_cycles++; we_addr = rf_wAddr; end
      if ((who == 0) ? ack0 : ack1) seen = 1'b1;
    end
    if (!seen) check("txn_ack_timeout", 32'd0, 32'd1);
    rd = rdata;
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    $display("txn req%0d %s addr=%0d wdata=%h rdata=%h latency=%0d", who, we ? "wr" : "rd", a, d, rd, lat);
  endtask

  initial begin
    int lat, wec, last_ack_cyc, nacks, cyc;
    logic [2:0] wa;
    logic [31:0] rd;
    logic exp_w, got_first;

    // Reset with both requesters asking for a read of never-written addr 5.
    req0 = 1'b1; req1 = 1'b1; addr0 = 3'd5; addr1 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_ack0", {31'b0, ack0}, 32'd0);
      check("reset_ack1", {31'b0, ack1}, 32'd0);
      check("reset_rf_we", {31'b0, rf_we}, 32'd0);
    end
    reset_n = 1'b1;
    got_first = 1'b0;
    for (int n = 0; n < 10 && !got_first; n++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) got_first = 1'b1;
    end
    check("first_grant_ack0", {31'b0, ack0}, 32'd1);
    check("first_grant_ack1", {31'b0, ack1}, 32'd0);
    check("unwritten_addr5", rdata, 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Write then read back through the other requester.
    run_txn(0, 1'b1, 3'd1, 32'h11111111, lat, wec, wa, rd);
    check("write_latency", lat, 32'd3);
    check("write_we_cycles", wec, 32'd1);
    check("write_we_addr", {29'b0, wa}, 32'd1);
    run_txn(1, 1'b0, 3'd1, 32'h0, lat, wec, wa, rd);
    check("read_back", rd, 32'h11111111);
    check("read_latency", lat, 32'd3);
    run_txn(0, 1'b1, 3'd6, 32'hdeadbeef, lat, wec, wa, rd);
    check("rdata_held_after_write", rd, 32'h11111111);

    // Sustained contention: both hold write requests.
    we0 = 1'b1; addr0 = 3'd2; wdata0 = 32'hff00ff00;
    we1 = 1'b1; addr1 = 3'd3; wdata1 = 32'h0000ffff;
    req0 = 1'b1; req1 = 1'b1;
    nacks = 0; last_ack_cyc = 0; cyc = 0;
    while (nacks < 6 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack0 || ack1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        exp_w = 1'b0;
`else
        exp_w = (nacks % 2 == 0);  // last grant was req0, so req1 goes first
`endif
        check("contention_winner", {31'b0, ack1}, {31'b0, exp_w});
        check("contention_one_hot", {31'b0, ack0 ^ ack1}, 32'd1);
        if (nacks > 0) check("contention_spacing", cyc - last_ack_cyc, 32'd3);
        last_ack_cyc = cyc;
        nacks++;
      end
    end
    check("contention_ack_count", nacks, 32'd6);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Reset lands while a req1 read is in ACCESS.
    we1 = 1'b0; addr1 = 3'd1; req1 = 1'b1;
    @(posedge clk); #1;
    check("access_busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("aborted_ack1", {31'b0, ack1}, 32'd0);
      @(posedge clk); #1;
    end
    we0 = 1'b0; addr0 = 3'd2; we1 = 1'b0; addr1 = 3'd3;
    req0 = 1'b1; req1 = 1'b1;
    got_first = 1'b0;
    for (int n = 0; n < 10 && !got_first; n++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) got_first = 1'b1;
    end
    check("post_reset_winner_ack0", {31'b0, ack0}, 32'd1);
    check("post_reset_rdata_addr2", rdata, 32'hff00ff00);
    req0 = 1'b0; req1 = 1'b0;

    // Random traffic; each requester drops req in its ack cycle.
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        we0 = 1'($urandom_range(0, 1)); addr0 = 3'($urandom_range(0, 7));
        wdata0 = $urandom; req0 = 1'b1;
      end
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        we1 = 1'($urandom_range(0, 1)); addr1 = 3'($urandom_range(0, 7));
        wdata1 = $urandom; req1 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
